// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter.
// Pin bit positions, width and reset value.
package counter_pkg;

  localparam int CNT_W = 8;

  localparam int EN_BIT  = 0;
  localparam int UP_BIT  = 1;
  localparam int LD_BIT  = 2;
  localparam int CLR_BIT = 3;

  localparam logic [CNT_W-1:0] RST_VAL = 8'h00;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLR,
    OP_LOAD,
    OP_INC,
    OP_DEC
  } op_e;

endpackage

// File: rtl/counter_core.sv
// Count register with clear/load/up/down priority.
// Macro COUNTER_SATURATE_EN clamps at the ends instead of wrapping.
module counter_core
  import counter_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         en,
  input  logic         up,
  input  logic         ld,
  input  logic         clr,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_V = {W{1'b1}};
  localparam logic [W-1:0] MIN_V = '0;

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic [W-1:0] inc_v;
  logic [W-1:0] dec_v;
  op_e          op;

  // Select one operation; clear beats load beats counting.
  always_comb begin
    op = OP_HOLD;
    if (clr)
      op = OP_CLR;
    else if (ld)
      op = OP_LOAD;
    else if (en && up)
      op = OP_INC;
    else if (en)
      op = OP_DEC;
  end

  // Neighbouring values, clamped or wrapping.
  always_comb begin
    inc_v = count_q + 1'b1;
    dec_v = count_q - 1'b1;
`ifdef COUNTER_SATURATE_EN
    if (count_q == MAX_V)
      inc_v = MAX_V;
    if (count_q == MIN_V)
      dec_v = MIN_V;
`endif
  end

  // Next count from the chosen operation.
  always_comb begin
    count_d = count_q;
    case (op)
      OP_CLR:  count_d = W'(RST_VAL);
      OP_LOAD: count_d = ld_val;
      OP_INC:  count_d = inc_v;
      OP_DEC:  count_d = dec_v;
      default: count_d = count_q;
    endcase
  end

  // Register; reset wins, ena low freezes.
  always_ff @(posedge clk) begin
    if (rst)
      count_q <= W'(RST_VAL);
    else if (ena)
      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/tt_um_claudiotalarico_counter.sv
// Pin wrapper for the 8-bit up/down counter.
// Optional macro: COUNTER_SATURATE_EN.
module tt_um_claudiotalarico_counter
  import counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [CNT_W-1:0] count;
  logic             unused_pins;

  // rst_n is active-high despite its name.
  counter_core #(
    .W (CNT_W)
  ) u_core (
    .clk    (clk),
    .rst    (rst_n),
    .ena    (ena),
    .en     (ui_in[EN_BIT]),
    .up     (ui_in[UP_BIT]),
    .ld     (ui_in[LD_BIT]),
    .clr    (ui_in[CLR_BIT]),
    .ld_val (uio_in),
    .count  (count)
  );

  assign uo_out      = count;
  assign uio_out     = 8'h00;
  assign uio_oe      = 8'h00;
  assign unused_pins = &{1'b0, ui_in[7:4]};

endmodule

// File: tb/tb_tt_um_claudiotalarico_counter.sv
// Directed and random checks of the counter
// against an arithmetic reference model.
module tb_tt_um_claudiotalarico_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks   = 0;
  int failures = 0;
  int model    = 0;

  tt_um_claudiotalarico_counter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  function automatic int ref_next(int cur, bit r, bit e,
                                  logic [7:0] ui,
                                  logic [7:0] ld);
    if (r)             return 0;
    if (!e)            return cur;
    if (ui[3])         return 0;
    if (ui[2])         return int'(ld);
    if (ui[0] && ui[1])
      return SAT ? (cur == 255 ? 255 : cur + 1)
                 : (cur + 1) % 256;
    if (ui[0])
      return SAT ? (cur == 0 ? 0 : cur - 1)
                 : (cur + 255) % 256;
    return cur;
  endfunction

  task automatic chk(string tag, logic [7:0] obs,
                     logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h",
             tag, obs, exp);
    end
  endtask

  // Drive at negedge, clock, then check model and tie-offs.
  task automatic step(bit r, bit e, logic [7:0] ui,
                      logic [7:0] ld);
    @(negedge clk);
    rst_n  = r;
    ena    = e;
    ui_in  = ui;
    uio_in = ld;
    model  = ref_next(model, r, e, ui, ld);
    @(posedge clk);
    #1;
    chk("model", uo_out, 8'(model));
    chk("uio_out", uio_out, 8'h00);
    chk("uio_oe", uio_oe, 8'h00);
  endtask

  initial begin
    logic [7:0] exp3 [3];
    rst_n  = 1'b1;
    ena    = 1'b0;
    ui_in  = 8'($urandom);
    uio_in = 8'($urandom);

    // Reset with random pins, 2 cycles
    repeat (2)
      step(1'b1, 1'($urandom), 8'($urandom), 8'($urandom));
    chk("reset", uo_out, 8'h00);

    // Up count 10 cycles
    repeat (10) step(1'b0, 1'b1, 8'h03, 8'($urandom));
    chk("up10", uo_out, 8'h0A);

    // Wrap or saturate from 0xFE
    step(1'b0, 1'b1, 8'h04, 8'hFE);
    chk("load_fe", uo_out, 8'hFE);
    if (SAT) begin
      exp3[0] = 8'hFF; exp3[1] = 8'hFF; exp3[2] = 8'hFF;
    end else begin
      exp3[0] = 8'hFF; exp3[1] = 8'h00; exp3[2] = 8'h01;
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'h03, 8'h00);
      chk("wrap", uo_out, exp3[i]);
    end

    // Down count and clear priority
    step(1'b0, 1'b1, 8'h04, 8'h01);
    step(1'b0, 1'b1, 8'h01, 8'h55);
    chk("down0", uo_out, 8'h00);
    step(1'b0, 1'b1, 8'h01, 8'h55);
    chk("down_under", uo_out, SAT ? 8'h00 : 8'hFF);
    step(1'b0, 1'b1, 8'h0F, 8'hAA);
    chk("clr_prio", uo_out, 8'h00);

    // Load beats count, upper ui bits ignored
    step(1'b0, 1'b1, 8'hF7, 8'h33);
    chk("ld_prio", uo_out, 8'h33);

    // Enable gating
    step(1'b0, 1'b1, 8'h04, 8'h05);
    repeat (4) step(1'b0, 1'b0, 8'h03, 8'($urandom));
    chk("ena_hold", uo_out, 8'h05);
    step(1'b0, 1'b1, 8'h03, 8'h00);
    chk("ena_go", uo_out, 8'h06);

    // Mid-operation reset
    step(1'b0, 1'b1, 8'h04, 8'h40);
    step(1'b1, 1'b1, 8'h07, 8'h99);
    chk("mid_rst", uo_out, 8'h00);
    step(1'b0, 1'b1, 8'h03, 8'h00);
    chk("post_rst", uo_out, 8'h01);

    // Random mix against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) == 0),
           ($urandom_range(0, 7) != 0),
           8'($urandom & 32'hF3 |
              ($urandom_range(0, 5) == 0 ? 32'h4 : 32'h0) |
              ($urandom_range(0, 9) == 0 ? 32'h8 : 32'h0)),
           8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
